rew_mask_engine: RTL and testbench

- Parametrised, command-driven keystream mask engine for the REW ORAM AES path.
- Generates counter-mode seeds {IV, BucketID, ChunkID} for a whole path (1..MaxBuckets buckets) and issues them to an external AES core.
- Packs the returned AESWidth masks into DataWidth flit masks and buffers them in a credit-limited FIFO.
- XORs each mask onto the DRAM/backend flit stream, preserving flit order and count exactly.

---
 rtl/rew_mask_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_rew_mask_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rew_mask_engine.sv
// Counter-mode keystream mask engine: issues {IV,bucket,chunk} seeds, packs returned masks, XORs flits.
// Optional REW_HEADER_ONLY_EN adds CmdHeaderOnly so only flit 0 of each bucket is masked.
//
// state | meaning
// IDLE  | waiting for a command, CmdReady high
// GEN   | issuing seeds, data may already flow
// DRAIN | all seeds issued, waiting for the last flit to leave the output register
module rew_mask_engine #(
  parameter int DataWidth  = 512,
  parameter int AESWidth   = 128,
  parameter int IVWidth    = 64,
  parameter int BIDWidth   = 8,
  parameter int CIDWidth   = 8,
  parameter int BktFlits   = 5,
  parameter int MaxBuckets = 33,
  parameter int MaskFlits  = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [IVWidth-1:0]   CmdIV,
  input  logic [BIDWidth-1:0]  CmdBuckets,
`ifdef REW_HEADER_ONLY_EN
  input  logic                 CmdHeaderOnly,
`endif
  input  logic                 CmdValid,
  output logic                 CmdReady,
  output logic [AESWidth-1:0]  SeedOut,
  output logic                 SeedValid,
  input  logic                 SeedReady,
  input  logic [AESWidth-1:0]  MaskIn,
  input  logic                 MaskInValid,
  input  logic [DataWidth-1:0] DataIn,
  input  logic                 DataInValid,
  output logic                 DataInReady,
  output logic [DataWidth-1:0] DataOut,
  output logic                 DataOutValid,
  input  logic                 DataOutReady,
  output logic                 Busy,
  output logic                 MaskError
);

  localparam int CPF        = DataWidth / AESWidth;
  localparam int BKT_CHUNKS = BktFlits * CPF;
  localparam int CREDIT_MAX = MaskFlits * CPF;
  localparam int CRD_W      = $clog2(CREDIT_MAX + 1);
  localparam int REM_W      = $clog2(MaxBuckets * BktFlits + 1);
  localparam int PTR_W      = (MaskFlits > 1) ? $clog2(MaskFlits) : 1;
  localparam int CNT_W      = $clog2(MaskFlits + 1);
  localparam int K_W        = (CPF > 1) ? $clog2(CPF) : 1;

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t               state;
  logic [IVWidth-1:0]   iv;
  logic [BIDWidth-1:0]  n_bkt;
  logic [BIDWidth-1:0]  b;
  logic [CIDWidth-1:0]  c;
  logic [CIDWidth-1:0]  chunk_last;
  logic [REM_W-1:0]     remaining;
  logic [CRD_W-1:0]     credit;
  logic [CRD_W-1:0]     outstanding;
  logic [K_W-1:0]       k;
  logic                 push_pend;
  logic [DataWidth-1:0] pack_buf;
  logic [DataWidth-1:0] fifo_mem [MaskFlits];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 out_valid;
  logic [DataWidth-1:0] out_data;
  logic                 mask_err;

  logic seed_fire;
  logic mask_ok;
  logic pass_thru;
  logic data_ready;
  logic data_fire;
  logic pop;

`ifdef REW_HEADER_ONLY_EN
  localparam int BF_W = (BktFlits > 1) ? $clog2(BktFlits) : 1;
  logic            hdr_only;
  logic [BF_W-1:0] bf;

  assign pass_thru  = hdr_only && (bf != '0);
  assign chunk_last = hdr_only ? CIDWidth'(CPF - 1) : CIDWidth'(BKT_CHUNKS - 1);
`else
  assign pass_thru  = 1'b0;
  assign chunk_last = CIDWidth'(BKT_CHUNKS - 1);
`endif

  assign CmdReady     = (state == IDLE);
  assign Busy         = (state != IDLE);
  assign SeedValid    = (state == GEN) && (credit < CRD_W'(CREDIT_MAX));
  assign SeedOut      = AESWidth'({iv, b, c});
  assign seed_fire    = SeedValid && SeedReady;
  assign mask_ok      = MaskInValid && (outstanding != '0);
  assign data_ready   = (state != IDLE) && (remaining != '0) &&
                        (!out_valid || DataOutReady) &&
                        (pass_thru || (fifo_cnt != '0));
  assign DataInReady  = data_ready;
  assign data_fire    = data_ready && DataInValid;
  assign pop          = data_fire && !pass_thru;
  assign DataOut      = out_data;
  assign DataOutValid = out_valid;
  assign MaskError    = mask_err;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      iv        <= '0;
      n_bkt     <= '0;
      b         <= '0;
      c         <= '0;
      remaining <= '0;
`ifdef REW_HEADER_ONLY_EN
      hdr_only  <= 1'b0;
      bf        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (CmdValid) begin
            iv        <= CmdIV;
            n_bkt     <= CmdBuckets;
            b         <= '0;
            c         <= '0;
            remaining <= REM_W'(int'(CmdBuckets) * BktFlits);
`ifdef REW_HEADER_ONLY_EN
            hdr_only  <= CmdHeaderOnly;
            bf        <= '0;
`endif
            state     <= GEN;
          end
        end
        GEN: begin
          if (seed_fire) begin
            if (c == chunk_last) begin
              c <= '0;
              b <= b + BIDWidth'(1);
              if (b == n_bkt - BIDWidth'(1)) state <= DRAIN;
            end else begin
              c <= c + CIDWidth'(1);
            end
          end
        end
        DRAIN: begin
          if ((remaining == '0) && !out_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (data_fire) begin
        remaining <= remaining - REM_W'(1);
`ifdef REW_HEADER_ONLY_EN
        bf <= (bf == BF_W'(BktFlits - 1)) ? '0 : bf + BF_W'(1);
`endif
      end
    end
  end

  // Credit reserves FIFO room per chunk at seed issue, so a returning mask always fits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      credit      <= '0;
      outstanding <= '0;
      k           <= '0;
      push_pend   <= 1'b0;
      mask_err    <= 1'b0;
    end else begin
      case ({seed_fire, pop})
        2'b10:   credit <= credit + CRD_W'(1);
        2'b01:   credit <= credit - CRD_W'(CPF);
        2'b11:   credit <= credit + CRD_W'(1) - CRD_W'(CPF);
        default: credit <= credit;
      endcase
      case ({seed_fire, mask_ok})
        2'b10:   outstanding <= outstanding + CRD_W'(1);
        2'b01:   outstanding <= outstanding - CRD_W'(1);
        default: outstanding <= outstanding;
      endcase
      push_pend <= mask_ok && (k == K_W'(CPF - 1));
      if (mask_ok) k <= (k == K_W'(CPF - 1)) ? '0 : k + K_W'(1);
      if (MaskInValid && (outstanding == '0)) mask_err <= 1'b1;
    end
  end

  // Packing buffer and FIFO storage carry no reset; validity lives in k and fifo_cnt.
  always_ff @(posedge Clock) begin
    if (mask_ok) pack_buf[k*AESWidth +: AESWidth] <= MaskIn;
    if (push_pend) fifo_mem[wr_ptr] <= pack_buf;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_pend) wr_ptr <= (wr_ptr == PTR_W'(MaskFlits - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= (rd_ptr == PTR_W'(MaskFlits - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_pend, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (data_fire) begin
      out_valid <= 1'b1;
      out_data  <= pass_thru ? DataIn : (DataIn ^ fifo_mem[rd_ptr]);
    end else if (DataOutReady) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rew_mask_engine.sv
// Directed-plus-random bench for rew_mask_engine against an index-arithmetic reference model.
module tb_rew_mask_engine;
  localparam int DW  = 512;
  localparam int AW  = 128;
  localparam int CPF = 4;
  localparam int BKT = 5;

  typedef struct {
    logic [AW-1:0] seed;
    int            due;
  } aes_t;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [63:0]   CmdIV;
  logic [7:0]    CmdBuckets;
`ifdef REW_HEADER_ONLY_EN
  logic          CmdHeaderOnly;
`endif
  logic          CmdValid;
  logic          CmdReady;
  logic [AW-1:0] SeedOut;
  logic          SeedValid;
  logic          SeedReady;
  logic [AW-1:0] MaskIn;
  logic          MaskInValid;
  logic [DW-1:0] DataIn;
  logic          DataInValid;
  logic          DataInReady;
  logic [DW-1:0] DataOut;
  logic          DataOutValid;
  logic          DataOutReady;
  logic          Busy;
  logic          MaskError;

  always #5 Clock = ~Clock;

  rew_mask_engine dut (
    .Clock(Clock), .Reset(Reset),
    .CmdIV(CmdIV), .CmdBuckets(CmdBuckets),
`ifdef REW_HEADER_ONLY_EN
    .CmdHeaderOnly(CmdHeaderOnly),
`endif
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .SeedOut(SeedOut), .SeedValid(SeedValid), .SeedReady(SeedReady),
    .MaskIn(MaskIn), .MaskInValid(MaskInValid),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .Busy(Busy), .MaskError(MaskError)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int seed_cnt, in_cnt, out_cnt, total, total_seeds, chunks;
  int last_out_cyc, busy_low_cyc, cr_viol;
  int aes_release, aes_lat;
  int unsigned seed_pct, din_pct, dout_pct;
  bit cmd_active, force_mask, data_zero, m_hdr;
  int m_n;
  logic [63:0]   m_iv;
  logic [AW-1:0] key, last_seed;
  logic [DW-1:0] din [256];
  aes_t aes_q [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] seed_of(input logic [63:0] iv, input int bb, input int cc);
    return {48'b0, iv, 8'(bb), 8'(cc)};
  endfunction

  // Flit f of the path takes chunks 4j..4j+3 of bucket f/5 (j = f%5); header-only masks j==0 only.
  function automatic logic [DW-1:0] exp_mask(input int f);
    logic [DW-1:0] m;
    int bkt;
    int j;
    m   = '0;
    bkt = f / BKT;
    j   = f % BKT;
    if (m_hdr && j != 0) return m;
    for (int q = 0; q < CPF; q++) m[q*AW +: AW] = seed_of(m_iv, bkt, j * CPF + q) ^ key;
    return m;
  endfunction

  task automatic cycle();
    aes_t e;
    SeedReady    = ($urandom_range(99) < seed_pct);
    DataInValid  = ($urandom_range(99) < din_pct);
    DataIn       = (in_cnt < total) ? din[in_cnt] : rand512();
    DataOutReady = ($urandom_range(99) < dout_pct);
    MaskInValid  = force_mask;
    MaskIn       = '0;
    if (!force_mask && aes_q.size() > 0 && aes_release != 0 && aes_q[0].due <= cyc) begin
      MaskInValid = 1'b1;
      MaskIn      = aes_q[0].seed ^ key;
      void'(aes_q.pop_front());
      if (aes_release > 0) aes_release--;
    end
    @(negedge Clock);
    if (SeedValid && SeedReady) begin
      chk("seed", DW'(SeedOut), DW'(seed_of(m_iv, seed_cnt / chunks, seed_cnt % chunks)));
      e.seed = SeedOut;
      e.due  = cyc + aes_lat;
      aes_q.push_back(e);
      last_seed = SeedOut;
      seed_cnt++;
    end
    if (DataInValid && DataInReady) in_cnt++;
    if (cmd_active && out_cnt < total && CmdReady) cr_viol++;
    if (DataOutValid && DataOutReady) begin
      if (out_cnt < total) chk("flit", DataOut, din[out_cnt] ^ exp_mask(out_cnt));
      else chk("extra_flit", DW'(out_cnt), DW'(total - 1));
      out_cnt++;
      last_out_cyc = cyc;
    end
    if (cmd_active && !Busy) begin
      cmd_active   = 1'b0;
      busy_low_cyc = cyc;
    end
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic start_cmd(input logic [63:0] iv, input int n, input bit hdr);
    m_iv = iv; m_n = n; m_hdr = hdr;
    chunks = hdr ? CPF : CPF * BKT;
    total = n * BKT;
    total_seeds = n * chunks;
    seed_cnt = 0; in_cnt = 0; out_cnt = 0; cr_viol = 0;
    last_out_cyc = -10; busy_low_cyc = -1;
    for (int i = 0; i < total; i++) din[i] = data_zero ? '0 : rand512();
    chk("cmd_ready_idle", DW'(CmdReady), DW'(1));
    CmdIV = iv;
    CmdBuckets = 8'(n);
`ifdef REW_HEADER_ONLY_EN
    CmdHeaderOnly = hdr;
`endif
    CmdValid = 1'b1;
    cycle();
    CmdValid = 1'b0;
    cmd_active = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input int budget);
    int n;
    n = 0;
    while (cmd_active && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done_in_budget"}, DW'(cmd_active), DW'(0));
    chk({tag, "_seed_count"}, DW'(seed_cnt), DW'(total_seeds));
    chk({tag, "_last_seed"}, DW'(last_seed), DW'(seed_of(m_iv, m_n - 1, chunks - 1)));
    chk({tag, "_flits_out"}, DW'(out_cnt), DW'(total));
    chk({tag, "_flits_in"}, DW'(in_cnt), DW'(total));
    chk({tag, "_cmdready_low"}, DW'(cr_viol), DW'(0));
    chk({tag, "_busy_fall"}, DW'(busy_low_cyc), DW'(last_out_cyc + 2));
    chk({tag, "_masks_returned"}, DW'(aes_q.size()), DW'(0));
    chk({tag, "_mask_error"}, DW'(MaskError), DW'(0));
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    CmdIV = '0; CmdBuckets = '0; CmdValid = 1'b0;
`ifdef REW_HEADER_ONLY_EN
    CmdHeaderOnly = 1'b0;
`endif
    SeedReady = 1'b0; MaskIn = '0; MaskInValid = 1'b0;
    DataIn = '0; DataInValid = 1'b0; DataOutReady = 1'b0;
    force_mask = 1'b0; cmd_active = 1'b0; data_zero = 1'b0; m_hdr = 1'b0;
    total = 0; in_cnt = 0; out_cnt = 0; seed_cnt = 0; chunks = 1;
    aes_release = -1; aes_lat = 3; key = '0; m_iv = '0; last_seed = '0; m_n = 1;
    seed_pct = 100; din_pct = 100; dout_pct = 100;

    #1;
    chk("rst_seed_valid", DW'(SeedValid), DW'(0));
    chk("rst_dout_valid", DW'(DataOutValid), DW'(0));
    chk("rst_din_ready", DW'(DataInReady), DW'(0));
    chk("rst_busy", DW'(Busy), DW'(0));
    chk("rst_mask_error", DW'(MaskError), DW'(0));
    chk("rst_cmd_ready", DW'(CmdReady), DW'(1));
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cycle();

    // N=1, IV=0x1234, masks equal seeds, zero data: flits show packed seeds
    key = '0; data_zero = 1'b1;
    start_cmd(64'h1234, 1, 1'b0);
    run_cmd("basic", 300);

    // Credit limit: no masks returned, issuance stalls at 32 seeds
    data_zero = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    aes_release = 0;
    start_cmd({$urandom, $urandom}, 2, 1'b0);
    repeat (60) cycle();
    chk("credit_stall_seeds", DW'(seed_cnt), DW'(32));
    chk("credit_stall_valid", DW'(SeedValid), DW'(0));
    chk("credit_stall_flits", DW'(out_cnt), DW'(0));
    aes_release = 4;
    repeat (30) cycle();
    chk("credit_refill_seeds", DW'(seed_cnt), DW'(36));
    chk("credit_refill_flits", DW'(out_cnt), DW'(1));
    chk("credit_refill_valid", DW'(SeedValid), DW'(0));
    aes_release = -1;
    run_cmd("credit", 1000);

    // Full path with AES latency 10 and 50% output backpressure
    aes_lat = 10; dout_pct = 50; seed_pct = 80; din_pct = 80;
    start_cmd({$urandom, $urandom}, 33, 1'b0);
    run_cmd("full_path", 6000);

    din_pct = 100; dout_pct = 100; seed_pct = 100;
    repeat (3) cycle();
    chk("idle_din_ready", DW'(DataInReady), DW'(0));
    chk("idle_no_accept", DW'(in_cnt), DW'(total));

    // Unsolicited mask in Idle sets a sticky error
    chk("mask_error_pre", DW'(MaskError), DW'(0));
    force_mask = 1'b1;
    cycle();
    force_mask = 1'b0;
    chk("mask_error_set", DW'(MaskError), DW'(1));
    repeat (5) cycle();
    chk("mask_error_sticky", DW'(MaskError), DW'(1));

    // Reset in the middle of a command
    aes_lat = 3;
    start_cmd({$urandom, $urandom}, 1, 1'b0);
    n = 0;
    while (seed_cnt < 7 && n < 100) begin
      cycle();
      n++;
    end
    chk("midrst_seeds", DW'(seed_cnt), DW'(7));
    Reset = 1'b1;
    #1;
    chk("midrst_seed_valid", DW'(SeedValid), DW'(0));
    chk("midrst_dout_valid", DW'(DataOutValid), DW'(0));
    chk("midrst_din_ready", DW'(DataInReady), DW'(0));
    chk("midrst_busy", DW'(Busy), DW'(0));
    chk("midrst_cmd_ready", DW'(CmdReady), DW'(1));
    chk("midrst_mask_error", DW'(MaskError), DW'(0));
    aes_q.delete();
    cmd_active = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    start_cmd({$urandom, $urandom}, 1, 1'b0);
    run_cmd("after_reset", 300);

`ifdef REW_HEADER_ONLY_EN
    start_cmd({$urandom, $urandom}, 2, 1'b1);
    run_cmd("header_only", 300);
`endif

    for (int t = 0; t < 3; t++) begin
      aes_lat  = $urandom_range(12, 1);
      seed_pct = $urandom_range(100, 30);
      din_pct  = $urandom_range(100, 30);
      dout_pct = $urandom_range(100, 30);
      key      = {$urandom, $urandom, $urandom, $urandom};
      start_cmd({$urandom, $urandom}, $urandom_range(33, 1), 1'b0);
      run_cmd("random", 8000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
